// File: rtl/display_pkg.sv
// Shared constants and helpers for the seven-segment display scanner.
// Supplies default timing, the digit-index width rule and the blank-anode pattern.
package display_pkg;

  localparam int DEFAULT_REFRESH_DIV = 50000;
  localparam int DEFAULT_ERR_HOLD    = 25000000;
  localparam int MAX_DIGITS          = 8;

  localparam logic [MAX_DIGITS-1:0] ANODE_OFF = 8'hFF;

  // A two-digit display still needs one index bit, so the width never drops below 1.
  function automatic int idx_width(input int num_digits);
    return (num_digits > 2) ? $clog2(num_digits) : 1;
  endfunction

endpackage

// File: rtl/refresh_prescaler.sv
// Free-running wrap counter that produces a one-cycle tick every DIV clocks.
// The tick marks the last cycle of each digit slot.
module refresh_prescaler
  import display_pkg::*;
#(
  parameter int DIV = DEFAULT_REFRESH_DIV
) (
  input  logic CLK,
  input  logic RST,
  output logic tick
);

  localparam int             CW   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

  logic [CW-1:0] r_count;

  assign tick = (r_count == LAST);

  // Slot counter: 0..DIV-1, wrapping on the tick.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_count <= '0;
    end else if (tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Scans a scrolling hex history of received UART bytes across a multiplexed display
// and holds an error LED for a fixed time after any framing or parity error.
module seven_seg_scanner
  import display_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV,
  parameter int ERR_HOLD    = DEFAULT_ERR_HOLD
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  par_err,
  input  logic                  stp_err,
  output logic [3:0]            bcd,
  output logic                  dec_en,
  output logic [NUM_DIGITS-1:0] anode,
  output logic                  err_led
);

  localparam int              IW       = idx_width(NUM_DIGITS);
  localparam int              NP       = NUM_DIGITS / 2;
  localparam int              EW       = $clog2(ERR_HOLD + 1);
  localparam logic [IW-1:0]   IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [EW-1:0]   ERR_LOAD = EW'(ERR_HOLD);

  logic                         w_tick;
  logic                         w_load;
  logic                         w_err;
  logic [IW-1:0]                w_idx_next;
  logic [EW-1:0]                w_err_cnt_next;
  logic [NUM_DIGITS-1:0]        w_anode_next;
  logic [3:0]                   w_bcd_next;
  logic                         w_den_next;

  logic [IW-1:0]                r_idx;
  logic [NUM_DIGITS-1:0][3:0]   r_digits;
  logic [NP-1:0]                r_valid;
  logic [EW-1:0]                r_err_cnt;
  logic                         r_err_led;
  logic [NUM_DIGITS-1:0]        r_anode;
  logic [3:0]                   r_bcd;
  logic                         r_dec_en;

  refresh_prescaler #(.DIV(REFRESH_DIV)) u_prescaler (
    .CLK  (CLK),
    .RST  (RST),
    .tick (w_tick)
  );

  assign w_load = rx_valid & ~par_err & ~stp_err;
  assign w_err  = rx_valid & (par_err | stp_err);

  // Next digit index: advances on the slot tick and wraps after the last digit.
  always_comb begin
    w_idx_next = r_idx;
    if (w_tick) begin
      if (r_idx == IDX_LAST) begin
        w_idx_next = '0;
      end else begin
        w_idx_next = r_idx + 1'b1;
      end
    end else begin
      w_idx_next = r_idx;
    end
  end

  // Error hold: a new error reloads the full hold, otherwise count down to zero.
  always_comb begin
    w_err_cnt_next = r_err_cnt;
    if (w_err) begin
      w_err_cnt_next = ERR_LOAD;
    end else if (r_err_cnt != '0) begin
      w_err_cnt_next = r_err_cnt - 1'b1;
    end else begin
      w_err_cnt_next = '0;
    end
  end

  // Output mux keyed on the upcoming index so the anode tracks the index with no lag;
  // digit contents are the ones held before any load happening this cycle.
  always_comb begin
    w_anode_next = ANODE_OFF[NUM_DIGITS-1:0];
    w_bcd_next   = 4'h0;
    w_den_next   = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (int'(w_idx_next) == k) begin
        w_anode_next[k] = 1'b0;
        w_bcd_next      = r_digits[k];
        w_den_next      = r_valid[k/2];
      end else begin
        w_anode_next[k] = 1'b1;
      end
    end
  end

  // Scroll history: each good byte pushes the older pairs up one position.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_digits <= '0;
      r_valid  <= '0;
    end else if (w_load) begin
      for (int k = NUM_DIGITS - 1; k >= 2; k--) begin
        r_digits[k] <= r_digits[k-2];
      end
      r_digits[1] <= rx_data[7:4];
      r_digits[0] <= rx_data[3:0];
      for (int p = NP - 1; p >= 1; p--) begin
        r_valid[p] <= r_valid[p-1];
      end
      r_valid[0] <= 1'b1;
    end else begin
      r_digits <= r_digits;
      r_valid  <= r_valid;
    end
  end

  // Index, error timer and registered display outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_idx     <= '0;
      r_err_cnt <= '0;
      r_err_led <= 1'b0;
      r_anode   <= ANODE_OFF[NUM_DIGITS-1:0];
      r_bcd     <= 4'h0;
      r_dec_en  <= 1'b0;
    end else begin
      r_idx     <= w_idx_next;
      r_err_cnt <= w_err_cnt_next;
      r_err_led <= (w_err_cnt_next != '0);
      r_anode   <= w_anode_next;
      r_bcd     <= w_bcd_next;
      r_dec_en  <= w_den_next;
    end
  end

  assign anode   = r_anode;
  assign bcd     = r_bcd;
  assign dec_en  = r_dec_en;
  assign err_led = r_err_led;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench: fixed vector table, error-hold and reset sequences, and
// randomized traffic checked against a byte-history reference model.
module tb_seven_seg_scanner;

  localparam int ND   = 4;
  localparam int DIV  = 4;
  localparam int HOLD = 10;

  logic          CLK;
  logic          RST;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          par_err;
  logic          stp_err;
  logic [3:0]    bcd;
  logic          dec_en;
  logic [ND-1:0] anode;
  logic          err_led;

  seven_seg_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(DIV), .ERR_HOLD(HOLD)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .par_err  (par_err),
    .stp_err  (stp_err),
    .bcd      (bcd),
    .dec_en   (dec_en),
    .anode    (anode),
    .err_led  (err_led)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [3:0] anode;
    logic [3:0] bcd;
    logic       den;
    logic       err;
  } vec_t;

  vec_t       tbl [16];
  int         n_cmp;
  int         n_bad;
  int         n_edges;
  int         last_err;
  logic [7:0] hist [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (edge %0d): got %0h expected %0h", nm, n_edges, act, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    n_edges  = 0;
    last_err = -100000;
  endtask

  // One clock: drive inputs, advance the reference model, compare all outputs.
  task automatic step(input logic v, input logic [7:0] d, input logic p, input logic s);
    int         idx;
    int         pair;
    logic [7:0] b;
    logic [3:0] one_hot;
    logic [3:0] e_anode;
    logic [3:0] e_bcd;
    logic       e_den;
    logic       e_err;
    rx_valid = v;
    rx_data  = d;
    par_err  = p;
    stp_err  = s;
    @(posedge CLK);
    n_edges++;
    idx     = (n_edges / DIV) % ND;
    one_hot = 4'b0001 << idx;
    e_anode = ~one_hot;
    pair    = idx / 2;
    if (pair < hist.size()) begin
      b     = hist[hist.size() - 1 - pair];
      e_bcd = (idx % 2 == 1) ? b[7:4] : b[3:0];
      e_den = 1'b1;
    end else begin
      e_bcd = 4'h0;
      e_den = 1'b0;
    end
    if (v && !p && !s) begin
      hist.push_back(d);
      if (hist.size() > ND / 2) void'(hist.pop_front());
    end
    if (v && (p || s)) last_err = n_edges;
    e_err = ((n_edges - last_err) < HOLD);
    #1;
    chk("anode", 32'(anode), 32'(e_anode));
    chk("bcd", 32'(bcd), 32'(e_bcd));
    chk("dec_en", 32'(dec_en), 32'(e_den));
    chk("err_led", 32'(err_led), 32'(e_err));
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    par_err  = 1'b0;
    stp_err  = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_anode"}, 32'(anode), 32'hF);
    chk({tag, "_bcd"}, 32'(bcd), 32'h0);
    chk({tag, "_dec_en"}, 32'(dec_en), 32'h0);
    chk({tag, "_err_led"}, 32'(err_led), 32'h0);
  endtask

  initial begin
    int hi;
    n_cmp = 0;
    n_bad = 0;
    model_reset();

    // Edge k of the table: inputs before edge k, outputs after it.
    tbl[0]  = '{1'b0, 8'h00, 4'hE, 4'h0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 8'hA5, 4'hE, 4'h0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 8'h00, 4'hE, 4'h5, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 8'h3C, 4'hD, 4'hA, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 4'hD, 4'h3, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 4'hD, 4'h3, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 8'h00, 4'hD, 4'h3, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 8'h00, 4'hB, 4'h5, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 8'h00, 4'hB, 4'h5, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 4'hB, 4'h5, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 4'hB, 4'h5, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 4'h7, 4'hA, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 8'h00, 4'h7, 4'hA, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 8'h00, 4'h7, 4'hA, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 8'h00, 4'h7, 4'hA, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 8'h00, 4'hE, 4'hC, 1'b1, 1'b0};

    RST      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    par_err  = 1'b0;
    stp_err  = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    chk_reset_outputs("reset");
    RST = 1'b1;

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].v, tbl[i].d, 1'b0, 1'b0);
      chk("tbl_anode", 32'(anode), 32'(tbl[i].anode));
      chk("tbl_bcd", 32'(bcd), 32'(tbl[i].bcd));
      chk("tbl_dec_en", 32'(dec_en), 32'(tbl[i].den));
      chk("tbl_err_led", 32'(err_led), 32'(tbl[i].err));
    end

    // Parity error: byte dropped, LED held for exactly HOLD cycles.
    step(1'b1, 8'h77, 1'b1, 1'b0);
    hi = err_led ? 1 : 0;
    for (int c = 0; c < 30; c++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      if (err_led) hi++;
      else break;
    end
    chk("err_hold_len", 32'(hi), 32'(HOLD));

    // Stop-bit error five cycles into a hold restarts the full hold.
    step(1'b1, 8'h55, 1'b1, 1'b0);
    repeat (4) step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h66, 1'b0, 1'b1);
    hi = err_led ? 1 : 0;
    for (int c = 0; c < 30; c++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      if (err_led) hi++;
      else break;
    end
    chk("err_restart_len", 32'(hi), 32'(HOLD));

    // Error flags without a strobe are ignored; back-to-back loads all land.
    step(1'b0, 8'h99, 1'b1, 1'b1);
    step(1'b1, 8'h12, 1'b0, 1'b0);
    step(1'b1, 8'h34, 1'b0, 1'b0);
    step(1'b1, 8'h56, 1'b0, 1'b0);
    repeat (16) step(1'b0, 8'h00, 1'b0, 1'b0);

    for (int c = 0; c < 400; c++) begin
      step(($urandom_range(0, 3) == 0), 8'($urandom),
           ($urandom_range(0, 11) == 0), ($urandom_range(0, 11) == 0));
    end

    // Asynchronous reset mid-scan with history loaded.
    step(1'b1, 8'hBE, 1'b0, 1'b0);
    step(1'b1, 8'hEF, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    #2;
    RST = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    @(posedge CLK);
    #2;
    chk_reset_outputs("held_reset");
    RST = 1'b1;
    model_reset();
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("restart_anode", 32'(anode), 32'hE);
    for (int c = 0; c < 19; c++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      chk("restart_blank", 32'(dec_en), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Upstream driver for the seven-segment decoder on the UART demo board.
- Captures each byte received from the UART RX path and keeps a scrolling history of the last NUM_DIGITS/2 bytes as hex nibbles.
- Time-multiplexes the digits: one digit per refresh slot, driving the decoder's bcd/en inputs and the board's active-low anodes.
- Flags framing/parity errors on a timed error LED.

Parameters:
- NUM_DIGITS, 4: digits on the display; even, 2..8.
- REFRESH_DIV, 50000: clock cycles per digit slot; >= 2.
- ERR_HOLD, 25000000: clock cycles err_led stays high after an error; >= 1.

Ports:
- CLK  in  1  system clock; all state on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte from the UART RX.
- rx_valid  in  1  one-cycle strobe; rx_data, par_err and stp_err are valid in this cycle.
- par_err  in  1  parity error for the strobed byte.
- stp_err  in  1  stop-bit error for the strobed byte.
- bcd  out  4  nibble for the seven-segment decoder.
- dec_en  out  1  decoder enable; 0 blanks the digit.
- anode  out  NUM_DIGITS  one-hot, active-low digit select.
- err_led  out  1  high while an error hold is active.

Behaviour:
- Reset (RST=0, asynchronous):
  - digit registers, valid mask, digit index, refresh counter and error counter all 0;
  - bcd=0, dec_en=0, anode=all ones, err_led=0.
- Refresh counter:
  - counts 0..REFRESH_DIV-1 and wraps;
  - tick = (count == REFRESH_DIV-1);
  - on tick, the digit index advances modulo NUM_DIGITS (NUM_DIGITS-1 wraps to 0).
- Byte load (rx_valid=1, par_err=0, stp_err=0):
  - digit pairs shift up one position: digits[k+2] <= digits[k], and the valid mask shifts likewise;
  - digit1 <= rx_data[7:4], digit0 <= rx_data[3:0], pair-0 valid <= 1;
  - the oldest pair is discarded.
- Error strobe (rx_valid=1 with par_err or stp_err):
  - the byte is dropped; digits and mask are unchanged;
  - the error counter loads ERR_HOLD, and a new error restarts the hold;
  - err_led = (error counter != 0); the counter decrements each cycle down to 0.
  - par_err/stp_err are ignored when rx_valid=0.
- Outputs are registered and updated every cycle from the current index:
  - anode <= ~(1 << index);
  - bcd <= digits[index];
  - dec_en <= valid mask of pair index/2.
  - Latency is one cycle from an index change or byte load to the outputs.
- Simultaneous tick and load in the same cycle: both take effect. Outputs in the next cycle show the new index and the pre-load digit contents; new contents appear on the cycle after.
- Never-loaded pairs stay blanked (dec_en=0, bcd=0) but are still scanned, with the anode asserted.
- Back-to-back rx_valid on consecutive cycles: every valid byte shifts in; none are lost.
- Reset mid-operation returns immediately to the reset state above; the history is cleared.

Decomposition:
- Shared package (display_pkg):
  - default REFRESH_DIV and ERR_HOLD;
  - digit-index width function clog2(NUM_DIGITS);
  - ANODE_OFF constant (all ones).
- One sub-module: refresh_prescaler, parameter DIV; ports CLK, RST, tick. Holds the wrap counter and emits the single-cycle tick.
- Scroll register, error timer and output mux stay in the top module.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, ERR_HOLD=10):
- Reset, then run 20 cycles with no input:
  - anode cycles 1110 -> 1101 -> 1011 -> 0111 -> 1110, each for 4 cycles;
  - dec_en=0 throughout; err_led=0.
- Valid strobe with rx_data=0xA5:
  - while anode=1110: bcd=5, dec_en=1;
  - while anode=1101: bcd=A, dec_en=1;
  - anodes 1011 and 0111: dec_en=0.
- Valid strobe 0xA5, then 0x3C:
  - digits 3..0 display A,5,3,C;
  - all dec_en=1 during a full scan.
- Strobe 0x77 with par_err=1 after 0x3C was loaded:
  - displayed digits unchanged;
  - err_led=1 for exactly 10 cycles after the strobe, then 0.
- Second stp_err strobe 5 cycles into the hold: err_led stays high 10 cycles from the second strobe.
- Assert RST=0 mid-scan with data loaded:
  - outputs go to anode=1111, dec_en=0, bcd=0, err_led=0 without waiting for a clock edge;
  - after release, the scan restarts at anode=1110 with all digits blanked.
